// File: rtl/regfile_ctx_pkg.sv
// Shared types for the context-switching register file.
// Sequencer state encoding and the default stack-pointer slot.
package regfile_ctx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } ctx_state_e;

  localparam int SP_IDX_DEF = 4;

endpackage

// File: rtl/regfile_ctx_seq.sv
// Save/restore sequencer: owns the state, the beat index and done.
// Handshake outputs are registered alongside the state.
module regfile_ctx_seq
  import regfile_ctx_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          save_req,
  input  logic          restore_req,
  input  logic          sv_ready,
  input  logic          rs_valid,
  output logic          busy,
  output logic          done,
  output logic          sv_valid,
  output logic          rs_ready,
  output logic [AW-1:0] idx
);

  localparam logic [AW-1:0] LAST = '1;

  ctx_state_e state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      sv_valid <= 1'b0;
      rs_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (save_req) begin
            state    <= ST_SAVE;
            idx      <= '0;
            busy     <= 1'b1;
            sv_valid <= 1'b1;
          end else if (restore_req) begin
            state    <= ST_RESTORE;
            idx      <= '0;
            busy     <= 1'b1;
            rs_ready <= 1'b1;
          end
        end
        ST_SAVE: begin
          if (sv_ready) begin
            idx <= idx + 1'b1;
            if (idx == LAST) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              sv_valid <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        ST_RESTORE: begin
          if (rs_valid) begin
            idx <= idx + 1'b1;
            if (idx == LAST) begin
              state    <= ST_IDLE;
              busy     <= 1'b0;
              rs_ready <= 1'b0;
              done     <= 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          sv_valid <= 1'b0;
          rs_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_ctx.sv
// Register file with a dedicated SP port and streamed
// context save/restore driven by regfile_ctx_seq.
module regfile_ctx
  import regfile_ctx_pkg::*;
#(
  parameter int DW     = 32,
  parameter int NREG   = 8,
  parameter int SP_IDX = SP_IDX_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [AW-1:0]    ra1,
  input  logic [AW-1:0]    ra2,
  output logic [DW-1:0]    rd1,
  output logic [DW-1:0]    rd2,
  input  logic [AW-1:0]    wa,
  input  logic [DW-1:0]    wd,
  input  logic             we,
  output logic [DW-1:0]    rdsp,
  input  logic [DW-1:0]    wdsp,
  input  logic             wesp,
  input  logic             save_req,
  input  logic             restore_req,
  output logic             busy,
  output logic             done,
  output logic [DW-1:0]    sv_data,
  output logic             sv_valid,
  input  logic             sv_ready,
  input  logic [DW-1:0]    rs_data,
  input  logic             rs_valid,
  output logic             rs_ready,
  output logic [NREG*DW-1:0] rf_flat
);

  localparam logic [AW-1:0] SPA = AW'(SP_IDX);
  localparam bit            BYP = (BYPASS != 0);

  logic [DW-1:0] regs [NREG];
  logic [AW-1:0] idx;
  logic          rs_we;
  logic          byp_w;
  logic          byp_sp;

  regfile_ctx_seq #(.AW(AW)) u_seq (
    .clk         (clk),
    .n_rst       (n_rst),
    .save_req    (save_req),
    .restore_req (restore_req),
    .sv_ready    (sv_ready),
    .rs_valid    (rs_valid),
    .busy        (busy),
    .done        (done),
    .sv_valid    (sv_valid),
    .rs_ready    (rs_ready),
    .idx         (idx)
  );

  assign rs_we = rs_ready & rs_valid;

  // SP write is issued last so it wins a collision on SP_IDX
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (rs_we) begin
      regs[idx] <= rs_data;
    end else if (!busy) begin
      if (we)   regs[wa]  <= wd;
      if (wesp) regs[SPA] <= wdsp;
    end
  end

  // Gating with n_rst keeps every read port at zero under reset
  assign byp_w  = BYP && !busy && we && n_rst;
  assign byp_sp = BYP && !busy && wesp && n_rst;

  function automatic logic [DW-1:0] rd_mux(input logic [AW-1:0] a);
    rd_mux = regs[a];
    if (byp_w && a == wa)   rd_mux = wd;
    if (byp_sp && a == SPA) rd_mux = wdsp;
  endfunction

  always_comb begin
    rd1  = rd_mux(ra1);
    rd2  = rd_mux(ra2);
    rdsp = rd_mux(SPA);
  end

  assign sv_data = regs[idx];

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign rf_flat[g*DW +: DW] = regs[g];
  end

endmodule

// File: tb/tb_regfile_ctx.sv
// Randomized self-checking bench for regfile_ctx against an
// array model of the register file and stream ordering.
module tb_regfile_ctx;

  localparam int DW   = 32;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int SP   = 4;

  logic clk = 1'b0;
  logic n_rst;
  logic [AW-1:0] ra1, ra2, wa;
  logic [DW-1:0] rd1, rd2, wd, rdsp, wdsp;
  logic we, wesp, save_req, restore_req;
  logic busy, done, sv_valid, sv_ready, rs_valid, rs_ready;
  logic [DW-1:0] sv_data, rs_data;
  logic [NREG*DW-1:0] rf_flat;

  always #5 clk = ~clk;

  regfile_ctx dut (
    .clk(clk), .n_rst(n_rst),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wa(wa), .wd(wd), .we(we),
    .rdsp(rdsp), .wdsp(wdsp), .wesp(wesp),
    .save_req(save_req), .restore_req(restore_req),
    .busy(busy), .done(done),
    .sv_data(sv_data), .sv_valid(sv_valid), .sv_ready(sv_ready),
    .rs_data(rs_data), .rs_valid(rs_valid), .rs_ready(rs_ready),
    .rf_flat(rf_flat)
  );

  logic [DW-1:0] m [NREG];
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag);
    for (int i = 0; i < NREG; i++)
      check(tag, rf_flat[i*DW +: DW], m[i]);
  endtask

  function automatic logic [31:0] ref_rd(input int a, input int wadr,
      input logic [31:0] d, input bit w, input logic [31:0] dsp,
      input bit wsp);
    ref_rd = m[a];
    if (w && a == wadr) ref_rd = d;
    if (wsp && a == SP) ref_rd = dsp;
  endfunction

  task automatic idle_cyc(input int a1, input int a2, input int wadr,
      input logic [31:0] d, input bit w, input logic [31:0] dsp,
      input bit wsp);
    ra1 = AW'(a1); ra2 = AW'(a2); wa = AW'(wadr);
    wd = d; we = w; wdsp = dsp; wesp = wsp;
    #4;
    check("rd1", rd1, ref_rd(a1, wadr, d, w, dsp, wsp));
    check("rd2", rd2, ref_rd(a2, wadr, d, w, dsp, wsp));
    check("rdsp", rdsp, ref_rd(SP, wadr, d, w, dsp, wsp));
    check("idle_busy", busy, 0);
    tick;
    if (w) m[wadr] = d;
    if (wsp) m[SP] = dsp;
    we = 0; wesp = 0;
    chk_all("wr_slot");
  endtask

  task automatic save_end;
    #4;
    check("save_done", done, 1);
    check("save_busy_end", busy, 0);
    check("save_valid_end", sv_valid, 0);
    tick;
    #4;
    check("save_done_once", done, 0);
    tick;
    chk_all("save_keep");
  endtask

  // mode 0: ready toggles 1,0,1..; 1: random; 2: always ready
  task automatic do_save(input bit both, input int mode,
                         input int stop_after);
    logic [31:0] q [NREG];
    int beats, cyc;
    for (int i = 0; i < NREG; i++) q[i] = m[i];
    save_req = 1; restore_req = both;
    tick;
    save_req = 0; restore_req = 0;
    beats = 0; cyc = 0;
    while (beats < NREG && cyc < 200) begin
      if (stop_after >= 0 && beats == stop_after) return;
      case (mode)
        0: sv_ready = (cyc % 2 == 0);
        1: sv_ready = 1'($urandom_range(0, 1));
        default: sv_ready = 1;
      endcase
      wa = AW'($urandom); ra1 = wa; wd = $urandom;
      we = 1'($urandom); wesp = 1'($urandom); wdsp = $urandom;
      #4;
      check("sv_valid", sv_valid, 1);
      check("save_busy", busy, 1);
      check("save_rs_ready", rs_ready, 0);
      check("sv_data", sv_data, q[beats]);
      check("save_nobyp", rd1, m[ra1]);
      if (sv_ready) beats++;
      tick;
      cyc++;
    end
    we = 0; wesp = 0; sv_ready = 0;
    if (beats < NREG) check("save_timeout", beats, NREG);
    save_end;
  endtask

  task automatic do_restore(input bit rnd);
    logic [31:0] vals [NREG];
    int beats, cyc;
    for (int i = 0; i < NREG; i++)
      vals[i] = rnd ? $urandom : 32'h80 + i;
    restore_req = 1;
    tick;
    restore_req = 0;
    beats = 0; cyc = 0;
    while (beats < NREG && cyc < 200) begin
      rs_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      rs_data = vals[beats];
      we = 1; wa = rnd ? AW'($urandom) : '0;
      wd = rnd ? $urandom : 32'hDEAD;
      wesp = rnd ? 1'($urandom) : 1'b0; wdsp = $urandom;
      ra1 = wa; ra2 = AW'(SP);
      #4;
      check("rs_ready", rs_ready, 1);
      check("rest_busy", busy, 1);
      check("rest_sv_valid", sv_valid, 0);
      check("rest_nobyp", rd1, m[ra1]);
      check("rest_nobyp_sp", rdsp, m[SP]);
      tick;
      if (rs_valid) begin
        m[beats] = vals[beats];
        check("rest_slot", rf_flat[beats*DW +: DW], m[beats]);
        beats++;
      end
      cyc++;
    end
    we = 0; wesp = 0; rs_valid = 0;
    if (beats < NREG) check("rest_timeout", beats, NREG);
    #4;
    check("rest_done", done, 1);
    check("rest_busy_end", busy, 0);
    check("rest_ready_end", rs_ready, 0);
    tick;
    #4;
    check("rest_done_once", done, 0);
    tick;
    chk_all("rest_val");
  endtask

  initial begin
    n_rst = 0;
    {ra1, ra2, wa, wd, we, wdsp, wesp} = '0;
    {save_req, restore_req, sv_ready, rs_data, rs_valid} = '0;
    for (int i = 0; i < NREG; i++) m[i] = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sv_valid", sv_valid, 0);
    check("rst_rs_ready", rs_ready, 0);
    chk_all("rst_slot");
    #10 n_rst = 1;
    tick;

    idle_cyc(3, 0, 3, 32'h1234, 1, 0, 0);
    idle_cyc(4, 1, 4, 32'hAAAA, 1, 32'h0FF0, 1);
    #1 check("sp_collide", rdsp, 32'h0FF0);

    for (int n = 0; n < 150; n++)
      idle_cyc($urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom, 1'($urandom),
               $urandom, 1'($urandom));

    for (int i = 0; i < NREG; i++)
      idle_cyc(i, SP, i, 32'h10 + i, 1, 0, 0);
    do_save(0, 0, -1);
    do_restore(0);
    do_save(1, 1, -1);
    do_restore(1);

    for (int i = 0; i < NREG; i++)
      idle_cyc(0, 0, i, $urandom | 1, 1, 0, 0);
    do_save(0, 2, 3);
    n_rst = 0;
    we = 1; wa = 2; ra1 = 2; wd = 32'h5; wesp = 1; wdsp = 32'h6;
    for (int i = 0; i < NREG; i++) m[i] = '0;
    #1;
    check("mid_busy", busy, 0);
    check("mid_sv_valid", sv_valid, 0);
    check("mid_rs_ready", rs_ready, 0);
    check("mid_done", done, 0);
    check("mid_rd1", rd1, 0);
    check("mid_rdsp", rdsp, 0);
    chk_all("mid_slot");
    #3 n_rst = 1;
    we = 0; wesp = 0; sv_ready = 1;
    tick;
    for (int n = 0; n < 4; n++) begin
      #4;
      check("post_done", done, 0);
      check("post_busy", busy, 0);
      check("post_sv_valid", sv_valid, 0);
      tick;
    end
    sv_ready = 0;
    chk_all("post_slot");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
